// File: rtl/rf_sb_regfile.sv
// ---------------------------------------------------------------------------
// rf_sb_regfile
//
// Parametrised register file with load extension, write-to-read bypass and a
// pending-write scoreboard that raises per-read-port hazard flags. Register 0
// is hardwired to zero. A third read port (dbg_sel/dbg_data) serves the debug
// register viewer and only ever shows stored contents.
//
// Parameters:
//   DATA_W  register width (>= 16)
//   ADDR_W  address width, depth = 2**ADDR_W
//   BYPASS  1 = same-cycle write data is forwarded to rd1/rd2 and a clearing
//           write suppresses the hazard flag in its own cycle
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   we, waddr, wdata     write port; wext selects extension, wclr retires
//                        the busy bit of waddr
//   pend_set, pend_addr  mark a register busy (long-latency producer issued)
//   ra1/rd1/haz1         read port 1 (rs) with hazard flag
//   ra2/rd2/haz2         read port 2 (rt) with hazard flag
//   dbg_sel/dbg_data     debug read port, never bypassed
//   busy_vec             scoreboard bits, bit 0 always 0
//
// Optional feature: define RF_TRACE_EN to print every committed write and
// every busy-bit set/clear during simulation.
// ---------------------------------------------------------------------------
module rf_sb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [2:0]             wext,
    input  logic                   wclr,
    input  logic                   pend_set,
    input  logic [ADDR_W-1:0]      pend_addr,
    input  logic [ADDR_W-1:0]      ra1,
    input  logic [ADDR_W-1:0]      ra2,
    output logic [DATA_W-1:0]      rd1,
    output logic [DATA_W-1:0]      rd2,
    output logic                   haz1,
    output logic                   haz2,
    input  logic [ADDR_W-1:0]      dbg_sel,
    output logic [DATA_W-1:0]      dbg_data,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int   DEPTH  = 2**ADDR_W;
    localparam logic BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [DATA_W-1:0] wdata_ext;
    logic              commit;
    logic              clr_hit1;
    logic              clr_hit2;

    // Load extension; the undefined codes 100 and 111 fall through as word.
    always_comb begin
        wdata_ext = wdata;
        case (wext)
            3'b001:  wdata_ext = {{(DATA_W-8){wdata[7]}},   wdata[7:0]};
            3'b101:  wdata_ext = {{(DATA_W-8){1'b0}},       wdata[7:0]};
            3'b010:  wdata_ext = {{(DATA_W-16){wdata[15]}}, wdata[15:0]};
            3'b110:  wdata_ext = {{(DATA_W-16){1'b0}},      wdata[15:0]};
            default: wdata_ext = wdata;
        endcase
    end

    assign commit = we && (waddr != '0);

    // Storage. Entry 0 is never written, and every read of address 0 is
    // forced to zero below, so it behaves as a hardwired zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit) begin
            regs_reg[waddr] <= wdata_ext;
        end
    end

    // Scoreboard next state. A set on the same address as a clear wins
    // because a new producer has issued after the retiring one.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit       = pend_set && (pend_addr == ADDR_W'(gi));
            assign clr_hit       = we && wclr && (waddr == ADDR_W'(gi));
            assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    // Read ports. Address 0 needs no special case in the bypass term since
    // commit already excludes waddr == 0.
    assign rd1 = (ra1 == '0) ? '0 :
                 (BYP_EN && commit && (waddr == ra1)) ? wdata_ext : regs_reg[ra1];
    assign rd2 = (ra2 == '0) ? '0 :
                 (BYP_EN && commit && (waddr == ra2)) ? wdata_ext : regs_reg[ra2];
    assign dbg_data = (dbg_sel == '0) ? '0 : regs_reg[dbg_sel];

    // A retiring write to the register being read hides the hazard only when
    // its data is actually forwarded to the read port.
    assign clr_hit1 = we && wclr && (waddr == ra1);
    assign clr_hit2 = we && wclr && (waddr == ra2);
    assign haz1 = (ra1 != '0) && busy_reg[ra1] && !(BYP_EN && clr_hit1);
    assign haz2 = (ra2 != '0) && busy_reg[ra2] && !(BYP_EN && clr_hit2);

`ifdef RF_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (commit) begin
                $display("rf_sb_regfile: write r%0d = 0x%h (wext=%b)", waddr, wdata_ext, wext);
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (busy_next[i] != busy_reg[i]) begin
                    $display("rf_sb_regfile: busy r%0d %s", i, busy_next[i] ? "set" : "clear");
                end
            end
        end
    end
`else
`endif

endmodule

// File: doc/rf_sb_regfile.md
Name: rf_sb_regfile

Overview:
Parametrised successor to the single-cycle CPU register file. It adds configurable data width and depth, signed and unsigned load extension, write-to-read bypass, and a pending-write scoreboard that drives per-read-port hazard flags. It sits in decode/writeback of the multi-cycle/pipelined MIPS core and feeds the debug register viewer through a third read port.

Parameters:
DATA_W, 32, register width in bits (must be at least 16).
ADDR_W, 5, address width; depth = 2**ADDR_W; register 0 is hardwired to zero.
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = read ports show only the stored contents.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-high.
we  in  1  write enable.
waddr  in  ADDR_W  write address.
wdata  in  DATA_W  raw write data.
wext  in  3  extension mode: 000 word, 001 lb, 010 lh, 011 lw, 101 lbu, 110 lhu; 100 and 111 treated as word.
wclr  in  1  this write retires a pending entry; clears the busy bit of waddr.
pend_set  in  1  mark pend_addr busy (a long-latency producer has issued).
pend_addr  in  ADDR_W  register to mark busy.
ra1, ra2  in  ADDR_W  read addresses (rs, rt).
rd1, rd2  out  DATA_W  read data.
haz1, haz2  out  1  the register read on ra1/ra2 is busy.
dbg_sel  in  ADDR_W  debug read address.
dbg_data  out  DATA_W  debug read data; never bypassed.
busy_vec  out  2**ADDR_W  scoreboard bits; bit 0 is always 0.

Behaviour:
- Reset (async): all registers are 0 and all busy bits are 0. rd1, rd2 and dbg_data read 0; haz1, haz2 and busy_vec are 0.
- Write value ext(wdata) per wext:
  - lb/lbu: sign- or zero-extend wdata[7:0].
  - lh/lhu: sign- or zero-extend wdata[15:0].
  - word, lw and undefined codes: wdata unchanged.
- Write timing: when we=1 and waddr!=0, ext(wdata) is stored at the rising edge. we=1 with waddr=0 is ignored and the register stays 0.
- Reads are combinational. Address 0 always returns 0.
- Bypass (BYPASS=1): if we=1, waddr!=0 and raN==waddr, then rdN=ext(wdata) in the same cycle. With BYPASS=0, rdN shows the old value until after the edge.
- Scoreboard updates at each edge:
  - pend_set=1 and pend_addr!=0 sets busy[pend_addr].
  - we=1 and wclr=1 clears busy[waddr].
  - Set and clear on the same address in the same cycle: set wins, so the bit stays 1 (a new producer has issued).
  - Set and clear on different addresses both take effect.
  - pend_set with pend_addr=0 is ignored.
- Hazard flags (combinational):
  - hazN = busy[raN] AND NOT (we AND wclr AND waddr==raN AND BYPASS), with raN!=0.
  - With BYPASS=0, the clearing write does not suppress hazN in its own cycle; the flag drops the next cycle.
- A write with wclr=0 to a busy register updates data but leaves busy set.
- rst asserted mid-operation clears data and scoreboard immediately. A write in the same cycle as rst is lost.
- Latency: 0 cycles for read, bypass and hazard; 1 edge for storage and busy update.

Optional Feature:
RF_TRACE_EN: when defined, every committed write (we=1, waddr!=0) emits a simulation $display on that edge. It prints the address, ext(wdata) and wext (not the stale array contents), plus a second line on every busy-bit set or clear. When undefined, no display statements are compiled and function is identical.

Test Plan:
1. Reset check: assert rst with the array preloaded by writes -> every rdN/dbg_data reads 0x00000000; busy_vec=0; haz1=haz2=0.
2. Extension: write r3 with wdata=0x123485F0 in turn for each mode, reading r3 after each write:
   - wext=001 (lb) -> 0xFFFFFFF0.
   - wext=101 (lbu) -> 0x000000F0.
   - wext=010 (lh) -> 0xFFFF85F0.
   - wext=110 (lhu) -> 0x000085F0.
   - wext=011 (lw) -> 0x123485F0.
3. Zero register: we=1, waddr=0, wdata=0xDEADBEEF; ra1=0 -> rd1=0 both the same cycle and the next.
4. Bypass: r5=0x11, then we=1, waddr=5, wdata=0x22, ra2=5 -> rd2=0x22 the same cycle with BYPASS=1; rd2=0x11 the same cycle and 0x22 the next with BYPASS=0.
5. Scoreboard:
   - pend_set r7 -> next cycle busy_vec[7]=1 and haz1=1 for ra1=7.
   - we=1, wclr=1, waddr=7, wdata=0x55 -> haz1=0 the same cycle (BYPASS=1) and rd1=0x55.
   - Next cycle busy[7]=0.
6. Collision and async reset: pend_set r9 together with a wclr write to r9 -> busy[9] stays 1. Then pulse rst between clock edges -> busy[9]=0 immediately and r9 reads 0.
